// File: rtl/one_hot_rr_arbiter_if.sv
// one_hot_rr_arbiter_if: request/grant bundle between requesters and the round-robin arbiter
interface one_hot_rr_arbiter_if #(
  parameter int CNT = 5,
  parameter int IDXW = CNT > 1 ? $clog2(CNT) : 1
);
  logic [CNT-1:0] req;
  logic [CNT-1:0] last;
  logic ack;
  logic [CNT-1:0] grant;
  logic grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic abort;
  modport master (output req, last, ack, input grant, grant_valid, grant_idx, abort);
  modport slave (input req, last, ack, output grant, grant_valid, grant_idx, abort);
endinterface

// File: rtl/one_hot_rr_arbiter.sv
// one_hot_rr_arbiter: registered one-hot round-robin grant; ONE_HOT_RR_ARB_PKT_LOCK_EN holds grant until last beat
module one_hot_rr_arbiter #(
  parameter int CNT = 5,
  parameter int IDXW = CNT > 1 ? $clog2(CNT) : 1
) (
  input logic clk,
  input logic rst_n,
  one_hot_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [CNT-1:0] grant_q, grant_d;
  logic [IDXW-1:0] idx_q, idx_d, ptr_q, ptr_d, win_idx, pos;
  logic abort_q, abort_d, win_found, last_ok, done, drop;
`ifdef ONE_HOT_RR_ARB_PKT_LOCK_EN
  assign last_ok = bus.last[idx_q];
`else
  logic unused_last;
  assign unused_last = ^bus.last;
  assign last_ok = 1'b1;
`endif
  assign done = state_q == BUSY && bus.ack && last_ok;
  assign drop = state_q == BUSY && !bus.req[idx_q] && !done;
  // scan from farthest to nearest so the nearest requester after ptr wins; ptr itself ranks last
  always_comb begin
    win_found = 1'b0;
    win_idx = '0;
    pos = '0;
    for (int k = CNT; k >= 1; k--) begin
      pos = IDXW'((int'(ptr_q) + k) % CNT);
      if (bus.req[pos]) begin
        win_found = 1'b1;
        win_idx = pos;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    abort_d = 1'b0;
    if (drop) begin
      state_d = IDLE;
      grant_d = '0;
      idx_d = '0;
      abort_d = 1'b1;
    end else if (state_q == IDLE || done) begin
      state_d = win_found ? BUSY : IDLE;
      grant_d = win_found ? CNT'(1) << win_idx : '0;
      idx_d = win_found ? win_idx : '0;
      ptr_d = win_found ? win_idx : ptr_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q <= '0;
      ptr_q <= IDXW'(CNT - 1);
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      abort_q <= abort_d;
    end
  end
  assign bus.grant = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.abort = abort_q;
endmodule

// File: tb/tb_one_hot_rr_arbiter.sv
// tb_one_hot_rr_arbiter: random and directed checks of CNT=5 and CNT=3 arbiters against a behavioural model
module tb_one_hot_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  one_hot_rr_arbiter_if #(.CNT(5)) if5 ();
  one_hot_rr_arbiter_if #(.CNT(3)) if3 ();
  one_hot_rr_arbiter #(.CNT(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));
  one_hot_rr_arbiter #(.CNT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  typedef struct {
    bit busy;
    int holder;
    int ptr;
    bit abort;
  } m_t;
  m_t m5, m3;
  function automatic m_t step(m_t s, int n, logic [4:0] r, logic [4:0] l, bit a);
    m_t t;
    int w;
    bit lk;
    bit done;
    t = s;
    t.abort = 1'b0;
    w = -1;
    for (int k = 1; k <= n; k++)
      if (r[3'((s.ptr + k) % n)]) begin
        w = (s.ptr + k) % n;
        break;
      end
`ifdef ONE_HOT_RR_ARB_PKT_LOCK_EN
    lk = l[3'(s.holder)];
`else
    lk = 1'b1;
`endif
    done = s.busy && a && lk;
    if (s.busy && !r[3'(s.holder)] && !done) begin
      t.busy = 1'b0;
      t.holder = 0;
      t.abort = 1'b1;
    end else if (!s.busy || done) begin
      t.busy = w >= 0;
      t.holder = w >= 0 ? w : 0;
      t.ptr = w >= 0 ? w : s.ptr;
    end
    return t;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    check("grant5", 32'(if5.grant), m5.busy ? 32'(1) << m5.holder : 32'd0);
    check("valid5", 32'(if5.grant_valid), 32'(m5.busy));
    check("idx5", 32'(if5.grant_idx), 32'(m5.holder));
    check("abort5", 32'(if5.abort), 32'(m5.abort));
    check("grant3", 32'(if3.grant), m3.busy ? 32'(1) << m3.holder : 32'd0);
    check("valid3", 32'(if3.grant_valid), 32'(m3.busy));
    check("idx3", 32'(if3.grant_idx), 32'(m3.holder));
    check("abort3", 32'(if3.abort), 32'(m3.abort));
  endtask
  task automatic cycle(input logic [4:0] r, input logic [4:0] l, input bit a);
    if5.req = r;
    if5.last = l;
    if5.ack = a;
    if3.req = r[2:0];
    if3.last = l[2:0];
    if3.ack = a;
    m5 = step(m5, 5, r, l, a);
    m3 = step(m3, 3, r, l, a);
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    if5.req = '0; if5.last = '0; if5.ack = 1'b0;
    if3.req = '0; if3.last = '0; if3.ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant5", 32'(if5.grant), 32'd0);
    rst_n = 1'b1;
    m5 = '{1'b0, 0, 4, 1'b0};
    m3 = '{1'b0, 0, 2, 1'b0};
  endtask
  initial begin
    int exp_pl [4];
    logic [4:0] r, l;
`ifdef ONE_HOT_RR_ARB_PKT_LOCK_EN
    exp_pl = '{0, 0, 0, 1};
`else
    exp_pl = '{0, 1, 0, 1};
`endif
    do_reset();
    for (int i = 0; i < 10; i++) cycle(5'b00000, 5'b00000, 1'b0);
    cycle(5'b00100, 5'b00000, 1'b0);
    check("single_grant", 32'(if5.grant), 32'b00100);
    check("single_idx", 32'(if5.grant_idx), 32'd2);
    cycle(5'b00000, 5'b00100, 1'b1);
    check("single_done", 32'(if5.grant), 32'd0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(5'b11111, 5'b11111, 1'b1);
      check("rotate_idx", 32'(if5.grant_idx), 32'(i % 5));
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(5'b00011, i == 3 ? 5'b00001 : 5'b00000, 1'b1);
      check("pkt_idx", 32'(if5.grant_idx), 32'(exp_pl[i]));
    end
    do_reset();
    cycle(5'b01000, 5'b00000, 1'b0);
    check("abort_setup", 32'(if5.grant_idx), 32'd3);
    cycle(5'b00000, 5'b00000, 1'b0);
    check("abort_pulse", 32'(if5.abort), 32'd1);
    check("abort_grant", 32'(if5.grant), 32'd0);
    cycle(5'b01001, 5'b00000, 1'b0);
    check("abort_wrap", 32'(if5.grant), 32'b00001);
    check("abort_clear", 32'(if5.abort), 32'd0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(5'b00101, 5'b11111, 1'b1);
      check("wrap3_idx", 32'(if3.grant_idx), i % 2 == 0 ? 32'd0 : 32'd2);
    end
    do_reset();
    r = 5'($urandom);
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      l = 5'($urandom);
      cycle(r, l, 1'($urandom));
      if (if3.grant_idx == 2'd3) check("idx3_range", 32'(if3.grant_idx), 32'd0);
      if (i == 200) begin
        cycle(5'b11111, 5'b00000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_grant5", 32'(if5.grant), 32'd0);
        check("async_valid5", 32'(if5.grant_valid), 32'd0);
        check("async_grant3", 32'(if3.grant), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m5 = '{1'b0, 0, 4, 1'b0};
        m3 = '{1'b0, 0, 2, 1'b0};
        cycle(5'b11111, 5'b00000, 1'b0);
        check("post_rst_idx", 32'(if5.grant_idx), 32'd0);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/one_hot_rr_arbiter.md
# one_hot_rr_arbiter

Round-robin arbiter that produces the registered one-hot select vector consumed directly by `one_hot_mux_2d.sel`. It arbitrates among CNT requesters, holds the grant for the duration of a transfer, and rotates priority on completion. Its grant output is one-hot or all-zero by construction, so the downstream mux's one-hot check never fires.

## Interface
Parameters:
- `CNT`, 5: number of requesters; matches the mux `CNT`.
- `IDXW`, `$clog2(CNT)` (minimum 1): width of `grant_idx`.

Ports:
- `clk`, input, 1: clock. All state is updated on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, CNT: per-requester request level.
- `last`, input, CNT: per-requester last-beat flag. Only the granted bit is sampled.
- `ack`, input, 1: downstream accepted the current beat. Ignored when `grant_valid=0`.
- `grant`, output, CNT: registered one-hot grant, or all-zero. Drives the mux `sel`.
- `grant_valid`, output, 1: equals `|grant`.
- `grant_idx`, output, IDXW: binary index of the granted requester. Holds 0 when idle.
- `abort`, output, 1: one-cycle pulse when the granted requester drops `req` before completion.

## Operation
- Pointer: `ptr` (IDXW bits) holds the last granted index. Search order is `ptr+1, ptr+2, …` modulo CNT; the first requester with `req=1` wins. The modulo wrap goes from CNT-1 to 0; it is not a power-of-two wrap.
- States: IDLE (`grant=0`) and BUSY (`grant` is one-hot).
- IDLE → BUSY: on an edge where `|req=1`. The winner is registered into `grant`, `grant_idx` and `ptr`.
- Completion: `ack & last[grant_idx]` in BUSY. With the macro undefined, completion is `ack` alone.
- On completion, the next winner is computed from the same-cycle `req` using the current `ptr`.
  - The current holder ranks last. It regains the grant only if it is the sole requester.
  - If any request exists, the FSM stays BUSY with the new grant and no idle cycle.
  - If no request exists, the FSM goes to IDLE.
- Abort: in BUSY, if `req[grant_idx]=0` and there is no completion on the same edge:
  - go to IDLE;
  - `ptr` keeps the aborted index;
  - `abort` pulses for one cycle.
- Simultaneous completion and `req` drop on the same edge: treated as a completion, with no abort.
- Grant changes only at completion, abort, or IDLE→BUSY. New requests arriving mid-transfer never preempt the current grant.

## Timing
- Reset values:
  - `grant=0`, `grant_valid=0`, `grant_idx=0`, `abort=0`;
  - `ptr=CNT-1`, so requester 0 has first priority after reset;
  - state is IDLE.
- Latency: `req` asserted in cycle t while IDLE gives `grant` valid in cycle t+1.
- Back-to-back: completion at edge e gives the new grant visible in the cycle after e.
- All outputs are registered; there is no combinational path from `req`, `last` or `ack` to any output.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously). The first grant after release uses requester-0 priority.

## Configuration
- `ONE_HOT_RR_ARB_PKT_LOCK_EN` defined (packet lock):
  - the grant is held across beats until an `ack` with `last[grant_idx]=1`;
  - arbitration is per packet.
- `ONE_HOT_RR_ARB_PKT_LOCK_EN` undefined:
  - the `last` input is ignored;
  - every `ack` is a completion;
  - arbitration is per beat.

## Test plan
- Reset then idle: `req=5'b00000` for 10 cycles → `grant=0`, `grant_valid=0`, `abort=0` throughout. Assert `rst_n` low mid-run → outputs are 0 within the same cycle.
- Single request: `req=5'b00100` at cycle 0 → `grant=5'b00100`, `grant_idx=2` at cycle 1. Pulse `ack` with `last[2]=1` → `grant=0` next cycle.
- Full rotation: `req=5'b11111` held, `ack=1`, `last=5'b11111` every cycle → grant sequence 0,1,2,3,4,0,… with no idle cycles.
- Packet lock (macro defined): `req=5'b00011`, requester 0 sends 3 beats with `last` on beat 3 and `ack` every cycle → grant stays `5'b00001` for 3 cycles, then `5'b00010`.
  - Macro undefined, same stimulus → grant alternates 0,1,0 every beat.
- Abort: grant on requester 3, drop `req[3]` with `ack=0` → `abort=1` for one cycle, `grant=0`. Re-assert `req=5'b01001` → grant goes to requester 0 (search starts after 3, wraps through 4 to 0).
- Non-power-of-two wrap: `CNT=3`, `req=3'b101`, repeated completions → grants alternate 0 and 2. The index never reaches 3.
